ptp_ts_queue: RTL

//  Timestamp queue directly downstream of the PTP packet parser.
//  - Latches the RTC time at each packet SOP.
//  - On each new PTP event indication from the parser, pushes {ptp_infor, sop_timestamp} into a FIFO.
//  - Host/CPU-side logic pops entries over a valid/ready handshake.
//  - Counts events dropped because the queue was full.

---
 rtl/ptp_ts_queue.sv | 116 +++++++++++
 1 files changed

// File: rtl/ptp_ts_queue.sv
// ptp_ts_queue: PTP event timestamp queue behind the packet parser.
// Captures the RTC time at every SOP. On each rising edge of ptp_found it
// pushes {ptp_infor, sop timestamp} into a 2**AW deep FIFO. The consumer pops
// entries through a valid/ready handshake. Events that arrive while the queue
// is full are discarded and counted in a saturating drop counter.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   int_valid, int_sop      stream qualifiers; SOP latches rtc_time
//   rtc_time [TS_W]         free-running RTC time
//   ptp_found, ptp_infor    parser event level and its 32-bit info word
//   q_flush                 synchronous clear of queue state and drop counter
//   q_ready                 consumer accepts the head entry
//   q_valid, q_data         head entry present / {infor, timestamp} (zero when empty)
//   q_count [AW+1]          stored entries, 0..2**AW
//   q_drop_cnt [16]         saturating count of events lost to a full queue
module ptp_ts_queue #(
    parameter int unsigned TS_W = 64,
    parameter int unsigned AW   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 int_valid,
    input  logic                 int_sop,
    input  logic [TS_W-1:0]      rtc_time,
    input  logic                 ptp_found,
    input  logic [31:0]          ptp_infor,
    input  logic                 q_flush,
    input  logic                 q_ready,
    output logic                 q_valid,
    output logic [32+TS_W-1:0]   q_data,
    output logic [AW:0]          q_count,
    output logic [15:0]          q_drop_cnt
);
    localparam int unsigned DW    = 32 + TS_W;
    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0]   mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [TS_W-1:0] ts_sop;
    logic            found_d1;
    logic            armed;
    logic            push_req;
    logic            pop;
    logic            full;
    logic            push_ok;
    logic            drop;

    // Edge detect and queue control. The first cycle after reset only primes
    // found_d1, so a level already high at reset release never pushes.
    always_comb begin
        push_req = ptp_found & ~found_d1 & armed;
        pop      = q_valid & q_ready;
        full     = (q_count == FULL_CNT);
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
    end

    // Zero-latency head read
    assign q_valid = (q_count != '0);
    assign q_data  = q_valid ? mem[rd_ptr] : '0;

    // SOP timestamp latch and event edge tracking (unaffected by flush)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_sop   <= '0;
            found_d1 <= 1'b0;
            armed    <= 1'b0;
        end else begin
            if (int_valid && int_sop) begin
                ts_sop <= rtc_time;
            end
            found_d1 <= ptp_found;
            armed    <= 1'b1;
        end
    end

    // Pointers, occupancy and drop counter; flush overrides push and pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            q_drop_cnt <= '0;
        end else if (q_flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            q_count    <= '0;
            q_drop_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({push_ok, pop})
                2'b10:   q_count <= q_count + (AW+1)'(1);
                2'b01:   q_count <= q_count - (AW+1)'(1);
                default: q_count <= q_count;
            endcase
            if (drop && (q_drop_cnt != 16'hFFFF)) begin
                q_drop_cnt <= q_drop_cnt + 16'd1;
            end
        end
    end

    // Entry storage, intentionally not reset
    always_ff @(posedge clk) begin
        if (push_ok && !q_flush) begin
            mem[wr_ptr] <= {ptp_infor, ts_sop};
        end
    end

endmodule
